// File: rtl/apb_reg_completer.sv
// APB completer with a bank of RW control registers, one RO status slot, and wait-state insertion.
// Optional byte-lane write strobes are enabled by defining APB_COMPLETER_PSTRB_EN.
module apb_reg_completer #(
    parameter int          NUM_REGS    = 8,
    parameter int          SEL_IDX     = 0,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
    input  logic                        PCLK,
    input  logic                        PRESETn,
    input  logic [31:0]                 PADDR,
    input  logic [15:0]                 PSEL,
    input  logic                        PENABLE,
    input  logic                        PWRITE,
    input  logic [31:0]                 PWDATA,
`ifdef APB_COMPLETER_PSTRB_EN
    input  logic [3:0]                  PSTRB,
`endif
    output logic [31:0]                 PRDATA,
    output logic                        PREADY,
    output logic                        PSLVERR,
    output logic [32*(NUM_REGS-1)-1:0]  reg_q,
    input  logic [31:0]                 status_i
);

    localparam int         NRW        = NUM_REGS - 1;
    localparam logic [9:0] STATUS_IDX = 10'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] prdata_q, prdata_d;
    logic        pready_q, pready_d;
    logic        pslverr_q, pslverr_d;
    logic [31:0] rw_q [NRW];

    logic        sel;
    logic [9:0]  idx;
    logic        err;
    logic        wrEn;
    logic [31:0] rdata;
    logic [31:0] wrMask;
    logic        unusedBits;

    assign sel        = PSEL[SEL_IDX];
    assign idx        = PADDR[11:2];
    assign err        = (PADDR[1:0] != 2'b00) || ({1'b0, idx} >= 11'(NUM_REGS))
                        || (PWRITE && (idx == STATUS_IDX));
    assign wrEn       = (state_q == S_DONE) && PWRITE && !err;
    assign unusedBits = ^{PADDR[31:12], PSEL};

`ifdef APB_COMPLETER_PSTRB_EN
    assign wrMask = {{8{PSTRB[3]}}, {8{PSTRB[2]}}, {8{PSTRB[1]}}, {8{PSTRB[0]}}};
`else
    assign wrMask = '1;
`endif

    always_comb begin
        rdata = '0;
        if (idx == STATUS_IDX) begin
            rdata = status_i;
        end else begin
            for (int i = 0; i < NRW; i++) begin
                if (idx == 10'(i)) begin
                    rdata = rw_q[i];
                end
            end
        end
    end

    // Outputs are loaded on the edge that enters DONE so they are valid for the whole DONE cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (sel && !PENABLE) begin
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d = 4'(WAIT_STATES);
                if (!sel) begin
                    state_d = S_IDLE;
                end else if (PENABLE) begin
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                if (!sel) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = (cnt_q != 4'd0) ? cnt_q - 4'd1 : 4'd0;
                    if (cnt_q <= 4'd1) begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = (sel && !PENABLE) ? S_SETUP : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_DONE) begin
            pready_d  = 1'b1;
            pslverr_d = err;
            if (!err && !PWRITE) begin
                prdata_d = rdata;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prdata_q  <= prdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
        end
    end

    // Writes commit on the completion edge, i.e. the edge that leaves DONE.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NRW; i++) begin
                rw_q[i] <= RESET_VAL;
            end
        end else if (wrEn) begin
            for (int i = 0; i < NRW; i++) begin
                if (idx == 10'(i)) begin
                    rw_q[i] <= (rw_q[i] & ~wrMask) | (PWDATA & wrMask);
                end
            end
        end
    end

    for (genvar g = 0; g < NRW; g++) begin : g_flat
        assign reg_q[32*g +: 32] = rw_q[g];
    end

    assign PRDATA  = prdata_q;
    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;

endmodule

// File: tb/tb_apb_reg_completer.sv
// Scoreboard bench for apb_reg_completer: two instances on one bus (SEL_IDX 0 / WAIT_STATES 1 and
// SEL_IDX 3 / WAIT_STATES 3), expected responses queued at drive time and popped on PREADY.
module tb_apb_reg_completer;

    typedef struct {
        logic [31:0] prdata;
        logic        pslverr;
        int          lat;
    } exp_t;

    logic         PCLK;
    logic         PRESETn;
    logic [31:0]  PADDR;
    logic [15:0]  PSEL;
    logic         PENABLE;
    logic         PWRITE;
    logic [31:0]  PWDATA;
    logic [3:0]   pstrb;
    logic [31:0]  status;
    logic [31:0]  prdata0, prdata1;
    logic         pready0, pready1;
    logic         pslverr0, pslverr1;
    logic [223:0] regq0, regq1;

    int           tgt;
    logic [31:0]  mdl [2][8];
    exp_t         sbq [$];
    int           nChecks;
    int           nFails;

    logic         curReady;
    logic         curSlverr;
    logic [31:0]  curRdata;

    assign curReady  = (tgt == 1) ? pready1  : pready0;
    assign curSlverr = (tgt == 1) ? pslverr1 : pslverr0;
    assign curRdata  = (tgt == 1) ? prdata1  : prdata0;

    apb_reg_completer #(.NUM_REGS(8), .SEL_IDX(0), .WAIT_STATES(1), .RESET_VAL(32'h0)) dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA),
`ifdef APB_COMPLETER_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0), .reg_q(regq0), .status_i(status)
    );

    apb_reg_completer #(.NUM_REGS(8), .SEL_IDX(3), .WAIT_STATES(3), .RESET_VAL(32'h0)) dut1 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PWDATA(PWDATA),
`ifdef APB_COMPLETER_PSTRB_EN
        .PSTRB(pstrb),
`endif
        .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1), .reg_q(regq1), .status_i(status)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    function automatic logic [223:0] packMdl(input int t);
        logic [223:0] v;
        for (int i = 0; i < 7; i++) v[32*i +: 32] = mdl[t][i];
        return v;
    endfunction

    task automatic clearMdl();
        for (int t = 0; t < 2; t++)
            for (int i = 0; i < 8; i++) mdl[t][i] = 32'h0;
    endtask

    // Full transfer on the currently targeted instance; the bus is left idle #1 after the completion edge.
    task automatic apbXfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
        exp_t        e;
        exp_t        got;
        int          lat;
        logic [2:0]  idx;
        logic        err;
        idx = addr[4:2];
        err = (addr[1:0] != 2'b00) || (addr[11:2] >= 10'd8) || (wr && addr[11:2] == 10'd7);
        e.pslverr = err;
        e.prdata  = (err || wr) ? 32'h0 : ((idx == 3'd7) ? status : mdl[tgt][idx]);
        e.lat     = ((tgt == 1) ? 3 : 1) + 1;
        sbq.push_back(e);
        PSEL    = (tgt == 1) ? 16'h0008 : 16'h0001;
        PENABLE = 1'b0;
        PWRITE  = wr;
        PADDR   = addr;
        PWDATA  = data;
        pstrb   = strb;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        lat = 0;
        while (!curReady && lat < 40) begin
            @(posedge PCLK); #1;
            lat++;
        end
        got = sbq.pop_front();
        nChecks++;
        if (!curReady) begin
            nFails++;
            $display("[TB] FAIL xfer_timeout addr=%h: PREADY=%b, required 1 within 40 cycles", addr, curReady);
        end else begin
            if (curSlverr !== got.pslverr) begin
                nFails++;
                $display("[TB] FAIL pslverr addr=%h: got %b, required %b", addr, curSlverr, got.pslverr);
            end
            nChecks++;
            if (curRdata !== got.prdata) begin
                nFails++;
                $display("[TB] FAIL prdata addr=%h: got %h, required %h", addr, curRdata, got.prdata);
            end
            nChecks++;
            if (lat !== got.lat) begin
                nFails++;
                $display("[TB] FAIL latency addr=%h: got %0d, required %0d", addr, lat, got.lat);
            end
        end
        if (wr && !err) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) mdl[tgt][idx][8*b +: 8] = data[8*b +: 8];
        end
        @(posedge PCLK); #1;
        PSEL    = 16'h0;
        PENABLE = 1'b0;
        nChecks++;
        if (curReady !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL pready_width addr=%h: got %b, required 0", addr, curReady);
        end
    endtask

    task automatic test_reset();
        tgt = 0;
        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        nChecks++;
        if ({pready0, pslverr0, prdata0} !== 34'h0) begin
            nFails++;
            $display("[TB] FAIL reset_outputs: got %h, required 0", {pready0, pslverr0, prdata0});
        end
        nChecks++;
        if (regq0 !== 224'h0) begin
            nFails++;
            $display("[TB] FAIL reset_regq: got %h, required 0", regq0);
        end
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        for (int a = 0; a < 8; a++) apbXfer(1'b0, 32'(a * 4), 32'h0, 4'hF);
    endtask

    task automatic test_write();
        tgt = 0;
        apbXfer(1'b1, 32'h004, 32'hDEAD_BEEF, 4'hF);
        apbXfer(1'b0, 32'h004, 32'h0, 4'hF);
        nChecks++;
        if (regq0[63:32] !== 32'hDEAD_BEEF) begin
            nFails++;
            $display("[TB] FAIL regq_slot1: got %h, required deadbeef", regq0[63:32]);
        end
        nChecks++;
        if (regq1 !== packMdl(1)) begin
            nFails++;
            $display("[TB] FAIL unselected_regq: got %h, required %h", regq1, packMdl(1));
        end
    endtask

    task automatic test_errors();
        tgt = 0;
        apbXfer(1'b1, 32'h01C, 32'hCAFE_0001, 4'hF);
        apbXfer(1'b0, 32'h020, 32'h0, 4'hF);
        apbXfer(1'b0, 32'h002, 32'h0, 4'hF);
        apbXfer(1'b1, 32'h006, 32'hCAFE_0002, 4'hF);
        apbXfer(1'b0, 32'h01C, 32'h0, 4'hF);
        nChecks++;
        if (regq0 !== packMdl(0)) begin
            nFails++;
            $display("[TB] FAIL err_regq: got %h, required %h", regq0, packMdl(0));
        end
    endtask

    task automatic test_abort();
        logic sawReady;
        tgt = 1;
        PSEL = 16'h0008; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h008; PWDATA = 32'h1234_5678;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        sawReady = 1'b0;
        repeat (2) begin
            @(posedge PCLK); #1;
            sawReady |= pready1;
        end
        PSEL = 16'h0; PENABLE = 1'b0;
        repeat (6) begin
            @(posedge PCLK); #1;
            sawReady |= pready1;
        end
        nChecks++;
        if (sawReady !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL abort_pready: got %b, required 0", sawReady);
        end
        nChecks++;
        if (regq1[95:64] !== mdl[1][2]) begin
            nFails++;
            $display("[TB] FAIL abort_slot2: got %h, required %h", regq1[95:64], mdl[1][2]);
        end
        apbXfer(1'b1, 32'h008, 32'h0BAD_F00D, 4'hF);
        apbXfer(1'b0, 32'h008, 32'h0, 4'hF);
    endtask

    task automatic test_back_to_back();
        tgt = 0;
        apbXfer(1'b1, 32'h000, 32'h1111_1111, 4'hF);
        apbXfer(1'b1, 32'h004, 32'h2222_2222, 4'hF);
        nChecks++;
        if (regq0[63:0] !== 64'h2222_2222_1111_1111) begin
            nFails++;
            $display("[TB] FAIL b2b_regq: got %h, required 2222222211111111", regq0[63:0]);
        end
        PSEL = 16'h0001; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h008; PWDATA = 32'h3333_3333;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESETn = 1'b0;
        #1;
        nChecks++;
        if (pready0 !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL rst_pready: got %b, required 0", pready0);
        end
        nChecks++;
        if (regq0 !== 224'h0) begin
            nFails++;
            $display("[TB] FAIL rst_regq: got %h, required 0", regq0);
        end
        clearMdl();
        PSEL = 16'h0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        apbXfer(1'b0, 32'h008, 32'h0, 4'hF);
        apbXfer(1'b0, 32'h000, 32'h0, 4'hF);
        tgt = 1;
        apbXfer(1'b0, 32'h008, 32'h0, 4'hF);
    endtask

`ifdef APB_COMPLETER_PSTRB_EN
    task automatic test_pstrb();
        tgt = 0;
        apbXfer(1'b1, 32'h000, 32'hFFFF_FFFF, 4'hF);
        apbXfer(1'b1, 32'h000, 32'h0000_0000, 4'b0101);
        apbXfer(1'b0, 32'h000, 32'h0, 4'hF);
        apbXfer(1'b1, 32'h000, 32'h0000_0000, 4'h0);
        nChecks++;
        if (regq0[31:0] !== 32'hFF00_FF00) begin
            nFails++;
            $display("[TB] FAIL pstrb_slot0: got %h, required ff00ff00", regq0[31:0]);
        end
    endtask
`endif

    initial begin
        nChecks = 0;
        nFails  = 0;
        tgt     = 0;
        clearMdl();
        PSEL = 16'h0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h0; PWDATA = 32'h0;
        pstrb = 4'hF;
        status = 32'hA5A5_0001;
        test_reset();
        test_write();
        test_errors();
        test_abort();
        test_back_to_back();
`ifdef APB_COMPLETER_PSTRB_EN
        test_pstrb();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
